// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
// Used by muldiv_unit and also by the decoder and hazard unit.
//   op_e         funct3 encodings of the eight M-extension operations
//   state_e      iterative unit FSM states
//   XLEN_DEFAULT default operand/result width
//   MIN_INT      most negative two's complement value at XLEN_DEFAULT
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] MIN_INT = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's complement negate.
// Produces operand magnitudes at accept and applies the result sign at the end.
//   val  in  W  input value
//   neg  in  1  negate when high
//   res  out W  neg ? -val : val
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int W = XLEN_DEFAULT
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (one result bit per cycle).
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   flush       abort any operation and return to IDLE (highest priority)
//   in_valid    A/B/Op valid; in_ready high only in IDLE
//   A, B, Op    operands and funct3 code, sampled only at accept
//   out_valid   Res valid, held until out_ready
//   out_ready   consumer takes Res
//   Res         result
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      Op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Res
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_V = '1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    // acc holds {high, low}: product/multiplier for MUL*, remainder/quotient for DIV*/REM*
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    op_e                 op_q, op_d;
    logic                neg_q, neg_d;

    op_e                 op_in;
    logic                a_signed, b_signed, sign_a, sign_b, res_neg_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;

    logic [XLEN:0]       add_sum, rem_sh, diff;
    logic [2*XLEN-1:0]   mul_step, div_step, acc_step, raw_res, fixed_res;
    logic [XLEN-1:0]     final_res;

    assign op_in = op_e'(Op);

    // Operand signedness and result sign decided once, at accept
    always_comb begin
        a_signed   = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed   = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sign_a     = a_signed & A[XLEN-1];
        sign_b     = b_signed & B[XLEN-1];
        // Remainder follows the dividend; everything else is the product/quotient sign
        res_neg_in = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);
    end

    muldiv_signfix #(.W(XLEN)) u_abs_a (.val(A), .neg(sign_a), .res(a_mag));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.val(B), .neg(sign_b), .res(b_mag));

    always_comb begin
        div_zero    = Op[2] && (B == '0);
        div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (A == MIN_V) && (B == ONES_V);
        special_res = '0;
        if (div_zero) begin
            special_res = (op_in inside {OP_DIV, OP_DIVU}) ? ONES_V : A;
        end else if (div_ovf) begin
            special_res = (op_in == OP_DIV) ? MIN_V : '0;
        end
    end

    // One iteration of shift-add multiply and of restoring division
    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
        mul_step = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, b_mag_q};
        // Borrow out means the trial subtract failed: keep the shifted remainder
        div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
        acc_step = op_q[2] ? div_step : mul_step;
        case (op_q)
            OP_DIV, OP_DIVU: raw_res = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
            OP_REM, OP_REMU: raw_res = {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]};
            default:         raw_res = acc_step;
        endcase
    end

    // Sign correction is over the full product so MULH* see the right upper half
    muldiv_signfix #(.W(2*XLEN)) u_fix_res (.val(raw_res), .neg(neg_q), .res(fixed_res));

    assign final_res = (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? fixed_res[2*XLEN-1:XLEN]
                                                                   : fixed_res[XLEN-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        acc_d   = acc_q;
        b_mag_d = b_mag_q;
        op_d    = op_q;
        neg_d   = neg_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        b_mag_d = b_mag;
                        op_d    = op_in;
                        neg_d   = res_neg_in;
                        if (div_zero || div_ovf) begin
                            res_d   = special_res;
                            state_d = DONE;
                        end else begin
                            cnt_d   = CW'(XLEN);
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CW'(1);
                    // Last bit: the corrected result comes straight off this iteration
                    if (cnt_q == CW'(1)) begin
                        res_d   = final_res;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Datapath registers are only meaningful once an operation is accepted
    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        b_mag_q <= b_mag_d;
        op_q    <= op_d;
        neg_q   <= neg_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Res       = res_q;

endmodule
